// File: rtl/vga_bounce_box.sv
// ---------------------------------------------------------------------------
// vga_bounce_box
// Pixel-generation stage that sits after the VGA sync/counter block. It draws
// a BOX_SIZE square in the sw colour over a background. The box bounces off
// the edges of the active area. Position updates happen only during vertical
// blank, so a visible frame never tears. All outputs are registered, which
// gives a fixed latency of one clock. hsync/vsync are re-registered so they
// stay aligned with rgb.
//
// Ports
//   clk        in   1   pixel clock
//   reset      in   1   asynchronous reset, active low
//   pixel_x    in  10   current column from the sync block
//   pixel_y    in  10   current row from the sync block
//   video_on   in   1   active-area flag from the sync block
//   hsync_in   in   1   horizontal sync from the sync block (active low)
//   vsync_in   in   1   vertical sync from the sync block (active low)
//   sw         in   3   box colour {R,G,B}
//   run        in   1   level: 1 animates the box, 0 holds it
//   hsync      out  1   hsync_in delayed one clock
//   vsync      out  1   vsync_in delayed one clock
//   rgb        out  3   pixel colour, aligned with hsync/vsync
//   frame_tick out  1   one-clock pulse per frame at the start of vertical blank
// ---------------------------------------------------------------------------
module vga_bounce_box #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned BOX_SIZE = 32,
    parameter int unsigned STEP     = 2,
    parameter logic [2:0]  BG_COLOR = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       video_on,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [2:0] sw,
    input  logic       run,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] rgb,
    output logic       frame_tick
);

    // 11-bit arithmetic width: position + size + step never wraps
    localparam int unsigned AW = 11;
    localparam int unsigned PW = 10;

    localparam logic [AW-1:0] H_LIM    = AW'(H_ACTIVE);
    localparam logic [AW-1:0] V_LIM    = AW'(V_ACTIVE);
    localparam logic [AW-1:0] BOX_W    = AW'(BOX_SIZE);
    localparam logic [AW-1:0] STEP_W   = AW'(STEP);
    localparam logic [PW-1:0] X_CENTRE = PW'((H_ACTIVE - BOX_SIZE) / 2);
    localparam logic [PW-1:0] Y_CENTRE = PW'((V_ACTIVE - BOX_SIZE) / 2);
    localparam logic [PW-1:0] TICK_ROW = PW'(V_ACTIVE);

    // Direction encoding: 1 = increasing coordinate, 0 = decreasing
    localparam logic DIR_POS = 1'b1;
    localparam logic DIR_NEG = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   box_x_q, box_x_d;
    logic [PW-1:0]   box_y_q, box_y_d;
    logic            dir_x_q, dir_x_d;
    logic            dir_y_q, dir_y_d;
    logic            hsync_q, hsync_d;
    logic            vsync_q, vsync_d;
    logic [2:0]      rgb_q,   rgb_d;
    logic            tick_q,  tick_d;

    logic            move;
    logic            in_box;
    logic [AW-1:0]   step_x;
    logic [AW-1:0]   step_y;

    // One-axis bounce step. Returns {new_dir, new_pos}. A wall hit clamps
    // the box to the wall and reverses the direction in the same step.
    function automatic logic [AW-1:0] step_axis(
        input logic [PW-1:0] pos,
        input logic          dir,
        input logic [AW-1:0] limit
    );
        logic [AW-1:0] p;
        p = {1'b0, pos};
        if (dir == DIR_POS) begin
            if (p + BOX_W + STEP_W > limit) begin
                step_axis = {DIR_NEG, PW'(limit - BOX_W)};
            end else begin
                step_axis = {DIR_POS, PW'(p + STEP_W)};
            end
        end else begin
            if (p < STEP_W) begin
                step_axis = {DIR_POS, {PW{1'b0}}};
            end else begin
                step_axis = {DIR_NEG, PW'(p - STEP_W)};
            end
        end
    endfunction

    // Box hit test for the current pixel.
    always_comb begin
        in_box = ({1'b0, pixel_x} >= {1'b0, box_x_q}) &&
                 ({1'b0, pixel_x} <  {1'b0, box_x_q} + BOX_W) &&
                 ({1'b0, pixel_y} >= {1'b0, box_y_q}) &&
                 ({1'b0, pixel_y} <  {1'b0, box_y_q} + BOX_W);
    end

    // Output pipeline: sync re-registration, colour select, frame tick.
    always_comb begin
        hsync_d = hsync_in;
        vsync_d = vsync_in;
        rgb_d   = 3'b000;
        tick_d  = (pixel_x == {PW{1'b0}}) && (pixel_y == TICK_ROW);
        if (video_on) begin
            rgb_d = in_box ? sw : BG_COLOR;
        end
    end

    // Candidate next positions. They are applied only when move is set.
    always_comb begin
        step_x = step_axis(box_x_q, dir_x_q, H_LIM);
        step_y = step_axis(box_y_q, dir_y_q, V_LIM);
    end

    // Animation FSM. It acts only on the clock where frame_tick is high.
    // run is sampled there, so run changes between ticks have no effect.
    always_comb begin
        state_d = state_q;
        move    = 1'b0;
        if (tick_q) begin
            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_d = S_RUN;
                        move    = 1'b1;
                    end
                end
                S_RUN: begin
                    if (run) begin
                        move = 1'b1;
                    end else begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (run) begin
                        state_d = S_RUN;
                        move    = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Position and direction update.
    always_comb begin
        box_x_d = box_x_q;
        box_y_d = box_y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        if (move) begin
            box_x_d = step_x[PW-1:0];
            dir_x_d = step_x[AW-1];
            box_y_d = step_y[PW-1:0];
            dir_y_d = step_y[AW-1];
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            box_x_q <= X_CENTRE;
            box_y_q <= Y_CENTRE;
            dir_x_q <= DIR_POS;
            dir_y_q <= DIR_POS;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= 3'b000;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            box_x_q <= box_x_d;
            box_y_q <= box_y_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            rgb_q   <= rgb_d;
            tick_q  <= tick_d;
        end
    end

    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign rgb        = rgb_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_vga_bounce_box.sv
// ---------------------------------------------------------------------------
// tb_vga_bounce_box
// Directed bench for vga_bounce_box. The bench itself plays the sync block.
// It drives individual pixels. A frame tick is produced by presenting
// (0,480), so many frames fit in a short run. An independent model of the
// box position gives the expected outputs. These are queued when a pixel is
// driven and compared when the registered output appears.
// ---------------------------------------------------------------------------
module tb_vga_bounce_box;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int BOX      = 32;
    localparam int STEPV    = 2;

    typedef struct packed {
        logic [2:0] rgb;
        logic       hs;
        logic       vs;
        logic       tick;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       hsync_in;
    logic       vsync_in;
    logic [2:0] sw;
    logic       run;
    logic       hsync;
    logic       vsync;
    logic [2:0] rgb;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;

    exp_t sb_q[$];

    // Model of the box.
    int bx, by;
    bit dx, dy;

    vga_bounce_box dut (
        .clk        (clk),
        .reset      (reset),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .video_on   (video_on),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .sw         (sw),
        .run        (run),
        .hsync      (hsync),
        .vsync      (vsync),
        .rgb        (rgb),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (bx=%0d by=%0d)", tag, obs, expv, bx, by);
        end
    endtask

    task automatic model_reset();
        bx = (H_ACTIVE - BOX) / 2;
        by = (V_ACTIVE - BOX) / 2;
        dx = 1'b1;
        dy = 1'b1;
    endtask

    task automatic axis_step(inout int pos, inout bit dir, input int limit);
        if (dir) begin
            if (pos + BOX + STEPV > limit) begin
                pos = limit - BOX;
                dir = 1'b0;
            end else begin
                pos = pos + STEPV;
            end
        end else begin
            if (pos < STEPV) begin
                pos = 0;
                dir = 1'b1;
            end else begin
                pos = pos - STEPV;
            end
        end
    endtask

    // Drive one pixel, queue its expected outputs, and compare one clock later.
    task automatic step(input int x, input int y, input bit von, input bit hs, input bit vs);
        exp_t e;
        exp_t got;
        bit inb;
        @(negedge clk);
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = von;
        hsync_in = hs;
        vsync_in = vs;
        inb = (x >= bx) && (x < bx + BOX) && (y >= by) && (y < by + BOX);
        e.rgb  = !von ? 3'b000 : (inb ? sw : 3'b000);
        e.hs   = hs;
        e.vs   = vs;
        e.tick = (x == 0) && (y == V_ACTIVE);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 8'd1, 8'd0);
        end else begin
            got = sb_q.pop_front();
            chk("rgb",        8'(rgb),        8'(got.rgb));
            chk("hsync",      8'(hsync),      8'(got.hs));
            chk("vsync",      8'(vsync),      8'(got.vs));
            chk("frame_tick", 8'(frame_tick), 8'(got.tick));
        end
    endtask

    // One vertical-blank tick. The second blank pixel is the clock where the
    // design acts on frame_tick, so the model moves only after it.
    task automatic do_tick();
        step(0, V_ACTIVE, 1'b0, 1'b1, 1'b0);
        step(1, V_ACTIVE, 1'b0, 1'b1, 1'b0);
        if (run) begin
            axis_step(bx, dx, H_ACTIVE);
            axis_step(by, dy, V_ACTIVE);
        end
    endtask

    // Probe the box edges to locate it. Row 480 at column 0 is never probed.
    task automatic probe();
        step(bx, by, 1'b1, 1'b1, 1'b1);
        step(bx + BOX - 1, by + BOX - 1, 1'b1, 1'b0, 1'b1);
        if (bx > 0) step(bx - 1, by, 1'b1, 1'b1, 1'b0);
        if (by > 0) step(bx, by - 1, 1'b1, 1'b1, 1'b1);
        if (bx + BOX < H_ACTIVE) step(bx + BOX, by + BOX - 1, 1'b1, 1'b1, 1'b1);
        if (by + BOX < V_ACTIVE) step(bx + BOX - 1, by + BOX, 1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        bit seen_right;
        bit seen_bottom;
        model_reset();
        reset    = 1'b0;
        pixel_x  = '0;
        pixel_y  = '0;
        video_on = 1'b0;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        sw       = 3'b100;
        run      = 1'b0;

        // Reset values while reset is held.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hsync", 8'(hsync),      8'd1);
        chk("reset_vsync", 8'(vsync),      8'd1);
        chk("reset_rgb",   8'(rgb),        8'd0);
        chk("reset_tick",  8'(frame_tick), 8'd0);
        @(negedge clk);
        reset = 1'b1;

        // Idle: box centred, no ticks away from (0,480), syncs delayed.
        step(0, 479, 1'b0, 1'b0, 1'b1);
        step(1, 480, 1'b0, 1'b1, 1'b0);
        step(0, 0,   1'b1, 1'b0, 1'b0);
        step(304, 224, 1'b1, 1'b1, 1'b1);
        step(303, 224, 1'b1, 1'b1, 1'b1);
        step(335, 255, 1'b1, 1'b1, 1'b1);
        step(336, 255, 1'b1, 1'b1, 1'b1);
        step(304, 256, 1'b1, 1'b1, 1'b1);
        step(304, 224, 1'b0, 1'b1, 1'b1);
        probe();

        // The box stays centred in IDLE across ticks while run is 0.
        repeat (2) begin
            do_tick();
            probe();
        end

        // Animate for three frames. The box should end at (310,230).
        run = 1'b1;
        repeat (3) begin
            do_tick();
            probe();
        end
        step(310, 230, 1'b1, 1'b1, 1'b1);
        step(309, 230, 1'b1, 1'b1, 1'b1);
        step(310, 229, 1'b1, 1'b1, 1'b1);

        // Long run: hit the bottom and right walls and reverse on both.
        // run glitches between ticks must be ignored.
        seen_right  = 1'b0;
        seen_bottom = 1'b0;
        for (int t = 0; t < 320; t++) begin
            if (t == 40) begin
                @(negedge clk);
                run = 1'b0;
                step(5, 5, 1'b1, 1'b1, 1'b1);
                run = 1'b1;
            end
            do_tick();
            probe();
            if (bx == H_ACTIVE - BOX) seen_right = 1'b1;
            if (by == V_ACTIVE - BOX) seen_bottom = 1'b1;
        end
        chk("reached_right_wall",  8'(seen_right),  8'd1);
        chk("reached_bottom_wall", 8'(seen_bottom), 8'd1);

        // Pause mid-frame: the position is held for five frames, then moves.
        step(100, 100, 1'b1, 1'b1, 1'b1);
        run = 1'b0;
        repeat (5) begin
            do_tick();
            probe();
        end
        run = 1'b1;
        do_tick();
        probe();

        // Blanking: a white box never shows while video_on is low.
        sw = 3'b111;
        for (int i = 0; i < 16; i++) begin
            step(bx + i, by + i, 1'b0, 1'(i % 2), 1'(i / 2 % 2));
            step(bx + i, by + i, 1'b1, 1'b1, 1'b1);
        end
        step(bx + 300 >= H_ACTIVE ? bx - 300 : bx + 300, 10, 1'b1, 1'b0, 1'b0);

        // A reset pulse mid-line clears the outputs at once.
        step(bx + 3, by + 3, 1'b1, 1'b0, 1'b0);
        #5;
        reset = 1'b0;
        #1;
        chk("async_rst_rgb",   8'(rgb),   8'd0);
        chk("async_rst_hsync", 8'(hsync), 8'd1);
        chk("async_rst_vsync", 8'(vsync), 8'd1);
        model_reset();
        run = 1'b0;
        sb_q.delete();
        @(negedge clk);
        reset = 1'b1;

        // After reset the box is centred again and IDLE. The first tick with
        // run high moves it by one step.
        probe();
        run = 1'b1;
        do_tick();
        probe();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog: the bench must always terminate.
    initial begin
        #5ms;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
